pipe_stage_reg: RTL

- Parametrised successor of the fixed ID/EX stage register; carries one pipeline-stage payload between any two stages of the ARM core.
- Payload is split into three fields:
  - control bits, zeroed on flush/bubble;
  - data bits, held, never cleared by flush;
  - status bits, preserved across flush.
- Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure from the next stage never needs a combinational ready path. Replaces the global freeze/flush hacks.

---
 rtl/pipe_stage_reg.sv | 90 +++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready stage register with 2-entry skid buffer; PIPE_STAGE_PERF_EN adds stall/bubble counters
module pipe_stage_reg #(
   parameter int CTRL_W = 9,
   parameter int DATA_W = 64,
   parameter int KEEP_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic [KEEP_W-1:0] in_keep,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [KEEP_W-1:0] out_keep
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
`endif
);
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
   state_t state, state_nx;
   logic [CTRL_W-1:0] h_ctrl, s_ctrl;
   logic [DATA_W-1:0] h_data, s_data;
   logic accept, consume, load_h, load_s, move_s;
   assign out_valid = state != EMPTY;
   assign accept    = in_valid & in_ready;
   assign consume   = out_valid & out_ready;
   assign load_h    = accept & (state == EMPTY | (state == ONE & consume));
   assign load_s    = accept & state == ONE & !consume;
   assign move_s    = state == TWO & consume;
   assign out_ctrl  = out_valid ? h_ctrl : '0;
   assign out_data  = h_data;
   always_comb begin
      state_nx = state;
      state_nx = flush ? EMPTY :
                 state == EMPTY ? (accept ? ONE : EMPTY) :
                 state == ONE ? (accept & !consume ? TWO : !accept & consume ? EMPTY : ONE) :
                 (consume ? ONE : TWO);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EMPTY;
         in_ready <= 1'b1;
         h_ctrl   <= '0;
         s_ctrl   <= '0;
         h_data   <= '0;
         s_data   <= '0;
         out_keep <= '0;
      end else begin
         state    <= state_nx;
         in_ready <= state_nx != TWO;
         if (accept) out_keep <= in_keep;
         // flush kills control only; data registers simply stop loading
         if (flush) begin
            h_ctrl <= '0;
            s_ctrl <= '0;
         end else begin
            if (load_h) begin
               h_ctrl <= in_ctrl;
               h_data <= in_data;
            end else if (move_s) begin
               h_ctrl <= s_ctrl;
               h_data <= s_data;
            end
            if (load_s) begin
               s_ctrl <= in_ctrl;
               s_data <= in_data;
            end
         end
      end
   end
`ifdef PIPE_STAGE_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (out_valid & !out_ready & !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
         if (!out_valid & !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 1'b1;
      end
   end
`endif
endmodule
